// File: rtl/ring_osc_meas_ctrl_pkg.sv
// Shared definitions for the ring oscillator measurement controller:
// FSM encoding, reset constants and default settle length.
package ring_osc_meas_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_COUNT  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_SETTLE = ST_SETTLE,
        S_COUNT  = ST_COUNT,
        S_DONE   = ST_DONE
    } state_t;

    localparam state_t RST_STATE  = S_IDLE;
    localparam logic   RST_OSC_EN = 1'b0;
    localparam logic   RST_BUSY   = 1'b0;
    localparam logic   RST_DONE   = 1'b0;
    localparam logic   RST_OVF    = 1'b0;

    localparam int SETTLE_CYC_DEF = 8;

endpackage

// File: rtl/ring_osc_meas_ctrl_if.sv
// Control/status bundle between the measurement controller and its host,
// including the ring enable, tap select and raw ring output.
interface ring_osc_meas_ctrl_if #(
    parameter int TAP_W = 2,
    parameter int WIN_W = 16,
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic [TAP_W-1:0] tap_sel_in;
    logic [WIN_W-1:0] win_cycles;
    logic             osc_in;
    logic             osc_en;
    logic [TAP_W-1:0] tap_sel;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             overflow;

    modport master (
        output start, abort, tap_sel_in, win_cycles, osc_in,
        input  osc_en, tap_sel, busy, done, count, overflow
    );

    modport slave (
        input  start, abort, tap_sel_in, win_cycles, osc_in,
        output osc_en, tap_sel, busy, done, count, overflow
    );
endinterface

// File: rtl/ring_osc_meas_ctrl_osc_edge_sync.sv
// Brings the asynchronous ring output into the clk domain through two flops
// and emits a one-cycle pulse per rising edge.
module ring_osc_meas_ctrl_osc_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic osc_i,
    output logic edge_o
);
    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= osc_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_o = s2_q & ~s3_q;
endmodule

// File: rtl/ring_osc_meas_ctrl.sv
// Gated ring oscillator sequencer: latch tap/window, enable the ring, settle,
// count synchronized rising edges over the window, then report.
module ring_osc_meas_ctrl
    import ring_osc_meas_ctrl_pkg::*;
#(
    parameter int NTAPS      = 4,
    parameter int TAP_W      = $clog2(NTAPS),
    parameter int WIN_W      = 16,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    ring_osc_meas_ctrl_if.slave  bus
);
    localparam logic [WIN_W-1:0] SETTLE_LOAD = WIN_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t           state_q;
    logic [WIN_W-1:0] timer_q;
    logic [WIN_W-1:0] win_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [TAP_W-1:0] tap_sel_q;
    logic             osc_en_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             osc_edge;

    ring_osc_meas_ctrl_osc_edge_sync u_edge_sync (
        .clk    (clk),
        .rst    (rst),
        .osc_i  (bus.osc_in),
        .edge_o (osc_edge)
    );

    // An edge arriving with the counter already full is a lost edge: flag it.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (state_q == S_COUNT && osc_edge) begin
            if (cnt_q == CNT_MAX) ovf_d = 1'b1;
            else                  cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RST_STATE;
            timer_q    <= '0;
            win_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= RST_OVF;
            tap_sel_q  <= '0;
            osc_en_q   <= RST_OSC_EN;
            busy_q     <= RST_BUSY;
            done_q     <= RST_DONE;
            count_q    <= '0;
            overflow_q <= RST_OVF;
        end else begin
            done_q <= 1'b0;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            if (state_q != S_IDLE && bus.abort) begin
                state_q  <= S_IDLE;
                osc_en_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start && !bus.abort) begin
                            tap_sel_q <= bus.tap_sel_in;
                            win_q     <= bus.win_cycles;
                            timer_q   <= SETTLE_LOAD;
                            cnt_q     <= '0;
                            ovf_q     <= 1'b0;
                            osc_en_q  <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= S_SETTLE;
                        end
                    end
                    S_SETTLE: begin
                        if (timer_q == '0) begin
                            if (win_q == '0) begin
                                state_q    <= S_DONE;
                                done_q     <= 1'b1;
                                count_q    <= cnt_q;
                                overflow_q <= ovf_q;
                                osc_en_q   <= 1'b0;
                            end else begin
                                state_q <= S_COUNT;
                                timer_q <= win_q - 1'b1;
                            end
                        end else begin
                            timer_q <= timer_q - 1'b1;
                        end
                    end
                    S_COUNT: begin
                        if (timer_q == '0) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            count_q    <= cnt_d;
                            overflow_q <= ovf_d;
                            osc_en_q   <= 1'b0;
                        end else begin
                            timer_q <= timer_q - 1'b1;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.osc_en   = osc_en_q;
    assign bus.tap_sel  = tap_sel_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_ring_osc_meas_ctrl.sv
// Directed bench for ring_osc_meas_ctrl built with a 4-bit edge counter so
// saturation is reachable; a synchronous square wave stands in for the ring.
module tb_ring_osc_meas_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   osc_period = 0;
    int   osc_phase  = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ring_osc_meas_ctrl_if #(.TAP_W(2), .WIN_W(16), .CNT_W(4)) bus ();

    ring_osc_meas_ctrl #(
        .NTAPS(4), .TAP_W(2), .WIN_W(16), .CNT_W(4), .SETTLE_CYC(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) begin
        if (osc_period == 0) begin
            osc_phase  = 0;
            bus.osc_in = 1'b0;
        end else begin
            if (osc_phase >= osc_period - 1) osc_phase = 0;
            else                             osc_phase = osc_phase + 1;
            bus.osc_in = (osc_phase < osc_period / 2);
        end
    end

    typedef struct {
        logic [1:0]  tap;
        logic [15:0] win;
        int          period;
        int          poke_at;
        int          exp_lat;
        int          exp_cnt;
        int          exp_ovf;
    } vec_t;

    vec_t vecs [7];

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int done_at = -1;
        int en_cnt  = 0;
        int tap_ok  = 1;
        int cnt_at  = -1;
        int ovf_at  = -1;
        osc_period = v.period;
        repeat (12) step();
        bus.tap_sel_in = v.tap;
        bus.win_cycles = v.win;
        bus.start      = 1'b1;
        for (int k = 1; k <= v.exp_lat + 20; k++) begin
            step();
            if (bus.osc_en) en_cnt++;
            if (bus.busy && bus.tap_sel != v.tap) tap_ok = 0;
            if (bus.done) begin
                done_at = k;
                cnt_at  = int'(bus.count);
                ovf_at  = int'(bus.overflow);
                break;
            end
            bus.start = (k == v.poke_at);
            if (k == 1) begin
                bus.tap_sel_in = ~v.tap;
                bus.win_cycles = 16'd3;
            end
            if (k == v.poke_at) begin
                bus.tap_sel_in = v.tap ^ 2'b01;
                bus.win_cycles = 16'd5;
            end
        end
        bus.start = 1'b0;
        chk($sformatf("v%0d_latency", idx), done_at, v.exp_lat);
        chk($sformatf("v%0d_osc_en_cycles", idx), en_cnt, v.exp_lat - 1);
        chk($sformatf("v%0d_count", idx), cnt_at, v.exp_cnt);
        chk($sformatf("v%0d_overflow", idx), ovf_at, v.exp_ovf);
        chk($sformatf("v%0d_tap_stable", idx), tap_ok, 1);
        step();
        chk($sformatf("v%0d_done_width", idx), int'(bus.done), 0);
        chk($sformatf("v%0d_busy_after", idx), int'(bus.busy), 0);
        chk($sformatf("v%0d_count_held", idx), int'(bus.count), v.exp_cnt);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int done_at;
        //        tap    win      per poke lat  cnt ovf
        vecs[0] = '{2'd2, 16'd100, 10, 0, 109, 10, 0};
        vecs[1] = '{2'd1, 16'd0,   10, 0,   9,  0, 0};
        vecs[2] = '{2'd3, 16'd200,  4, 0, 209, 15, 1};
        vecs[3] = '{2'd0, 16'd8,    4, 0,  17,  2, 0};
        vecs[4] = '{2'd2, 16'd40,  10, 15, 49,  4, 0};
        vecs[5] = '{2'd1, 16'd1,    0, 0,  10,  0, 0};
        vecs[6] = '{2'd1, 16'd30,   6, 0,  39,  5, 0};

        bus.start      = 1'b1;
        bus.abort      = 1'b0;
        bus.tap_sel_in = 2'd3;
        bus.win_cycles = 16'd50;
        repeat (3) step();
        chk("rst_osc_en",   int'(bus.osc_en),   0);
        chk("rst_busy",     int'(bus.busy),     0);
        chk("rst_done",     int'(bus.done),     0);
        chk("rst_count",    int'(bus.count),    0);
        chk("rst_overflow", int'(bus.overflow), 0);
        chk("rst_tap_sel",  int'(bus.tap_sel),  0);
        rst       = 1'b0;
        bus.start = 1'b0;
        step();
        chk("rst_start_ignored", int'(bus.busy), 0);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Abort 20 cycles into COUNT, then restart two cycles later.
        osc_period = 10;
        repeat (12) step();
        bus.tap_sel_in = 2'd1;
        bus.win_cycles = 16'd100;
        bus.start      = 1'b1;
        done_at = -1;
        for (int k = 1; k <= 80; k++) begin
            step();
            if (k == 28) chk("abort_osc_en_before", int'(bus.osc_en), 1);
            if (k == 29) begin
                chk("abort_osc_en", int'(bus.osc_en), 0);
                chk("abort_busy",   int'(bus.busy),   0);
                chk("abort_count_kept", int'(bus.count), 5);
            end
            if (k >= 29 && k <= 30) chk($sformatf("abort_no_done_%0d", k), int'(bus.done), 0);
            if (k == 31) begin
                chk("restart_busy",   int'(bus.busy),   1);
                chk("restart_osc_en", int'(bus.osc_en), 1);
            end
            if (bus.done) begin
                done_at = k;
                chk("restart_count",   int'(bus.count),   2);
                chk("restart_tap_sel", int'(bus.tap_sel), 3);
                break;
            end
            bus.start = (k == 30);
            bus.abort = (k == 28);
            if (k == 30) begin
                bus.tap_sel_in = 2'd3;
                bus.win_cycles = 16'd20;
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("restart_latency", done_at, 59);
        step();

        // start together with abort in IDLE is ignored.
        bus.start      = 1'b1;
        bus.abort      = 1'b1;
        bus.tap_sel_in = 2'd0;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("start_abort_busy",    int'(bus.busy),    0);
        chk("start_abort_osc_en",  int'(bus.osc_en),  0);
        chk("start_abort_tap_sel", int'(bus.tap_sel), 3);
        step();
        chk("start_abort_idle", int'(bus.busy), 0);

        // Reset mid-run clears everything, including the reported count.
        bus.tap_sel_in = 2'd2;
        bus.win_cycles = 16'd50;
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (20) step();
        chk("midrun_busy_before", int'(bus.busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrun_rst_busy",    int'(bus.busy),    0);
        chk("midrun_rst_osc_en",  int'(bus.osc_en),  0);
        chk("midrun_rst_count",   int'(bus.count),   0);
        chk("midrun_rst_tap_sel", int'(bus.tap_sel), 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
